cov_sum_collector: RTL and testbench

COV_SUM_COLLECTOR -- requirements
Module: cov_sum_collector

---
 rtl/cov_pkg.sv | 15 +
 rtl/cov_bitmap.sv | 36 +++
 rtl/cov_sum_collector.sv | 123 ++++++++++++
 tb/tb_cov_sum_collector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cov_pkg.sv
// Shared defaults and FSM state encoding for the coverage-sum collector.
package cov_pkg;

   localparam int unsigned DEF_MAP_BITS = 10;
   localparam int unsigned DEF_SUM_W    = 30;
   localparam int unsigned WORD_W       = 32;
   localparam int unsigned BIT_W        = $clog2(WORD_W);
   localparam int unsigned DROP_W       = 16;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/cov_bitmap.sv
// Seen-bitmap of 32-bit words: one word zeroed per sweep cycle, or one bit
// read-modify-written per cycle, reporting whether that bit was previously clear.
module cov_bitmap
   import cov_pkg::*;
#(
   parameter int unsigned MAP_BITS = DEF_MAP_BITS
) (
   input  logic                         clock,
   input  logic                         clr_en_i,
   input  logic [MAP_BITS-BIT_W-1:0]    clr_addr_i,
   input  logic                         rmw_en_i,
   input  logic [MAP_BITS-1:0]          rmw_idx_i,
   output logic                         rmw_new_c_o
);

   localparam int unsigned AW     = MAP_BITS - BIT_W;
   localparam int unsigned NWORDS = 1 << AW;

   logic [WORD_W-1:0] mem_q [NWORDS];
   logic [AW-1:0]     rmw_word;
   logic [BIT_W-1:0]  rmw_bit;

   assign rmw_word    = rmw_idx_i[MAP_BITS-1:BIT_W];
   assign rmw_bit     = rmw_idx_i[BIT_W-1:0];
   assign rmw_new_c_o = rmw_en_i && !mem_q[rmw_word][rmw_bit];

   // Storage is left unreset; a full sweep always precedes any use.
   always_ff @(posedge clock) begin
      if (clr_en_i) begin
         mem_q[clr_addr_i] <= '0;
      end else if (rmw_en_i) begin
         mem_q[rmw_word][rmw_bit] <= 1'b1;
      end
   end

endmodule

// File: rtl/cov_sum_collector.sv
// Counts distinct coverage points hit since the last clear, sweeping the bitmap
// on reset and meta_reset. Define COV_DROP_CNT_EN to add the cov_drop counter.
module cov_sum_collector
   import cov_pkg::*;
#(
   parameter int unsigned MAP_BITS = DEF_MAP_BITS,
   parameter int unsigned SUM_W    = DEF_SUM_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                meta_reset,
   input  logic                cov_valid,
   input  logic [MAP_BITS-1:0] cov_idx,
   output logic                cov_ready,
   output logic [SUM_W-1:0]    cov_sum,
   output logic                clearing
`ifdef COV_DROP_CNT_EN
   ,
   output logic [DROP_W-1:0]   cov_drop
`endif
);

   localparam int unsigned AW     = MAP_BITS - BIT_W;
   localparam int unsigned NWORDS = 1 << AW;

   if (SUM_W <= MAP_BITS || MAP_BITS <= BIT_W) begin : g_bad_cfg
      $error("cov_sum_collector: need SUM_W > MAP_BITS > BIT_W");
   end

   state_t              state_q;
   logic [AW-1:0]       ptr_q;
   logic                clearing_q;
   logic                s1_valid_q;
   logic [MAP_BITS-1:0] s1_idx_q;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic                rmw_en;
   logic                rmw_new;

   assign cov_ready = (state_q == ST_RUN) && !meta_reset;
   assign rmw_en    = s1_valid_q && (state_q == ST_RUN) && !meta_reset;
   assign cov_sum   = sum_q;
   assign clearing  = clearing_q;

   // Sweep/run FSM; meta_reset restarts the sweep from word 0.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_CLEAR;
         ptr_q      <= '0;
         clearing_q <= 1'b1;
      end else if (state_q == ST_CLEAR) begin
         if (meta_reset) begin
            ptr_q <= '0;
         end else if (ptr_q == AW'(NWORDS - 1)) begin
            state_q    <= ST_RUN;
            clearing_q <= 1'b0;
            ptr_q      <= '0;
         end else begin
            ptr_q <= ptr_q + AW'(1);
         end
      end else if (meta_reset) begin
         state_q    <= ST_CLEAR;
         clearing_q <= 1'b1;
         ptr_q      <= '0;
      end
   end

   always_comb begin
      sum_d = sum_q;
      if (meta_reset) begin
         sum_d = '0;
      end else if (rmw_new) begin
         sum_d = sum_q + SUM_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         sum_q      <= '0;
      end else begin
         s1_valid_q <= cov_valid && cov_ready;
         sum_q      <= sum_d;
      end
   end

   always_ff @(posedge clock) begin
      s1_idx_q <= cov_idx;
   end

   cov_bitmap #(
      .MAP_BITS (MAP_BITS)
   ) u_bitmap (
      .clock       (clock),
      .clr_en_i    (state_q == ST_CLEAR),
      .clr_addr_i  (ptr_q),
      .rmw_en_i    (rmw_en),
      .rmw_idx_i   (s1_idx_q),
      .rmw_new_c_o (rmw_new)
   );

`ifdef COV_DROP_CNT_EN
   logic [DROP_W-1:0] drop_q, drop_d;

   // Saturating count of offered-but-refused cycles; only reset clears it.
   always_comb begin
      drop_d = drop_q;
      if (cov_valid && !cov_ready && drop_q != {DROP_W{1'b1}}) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign cov_drop = drop_q;
`endif

endmodule

// File: tb/tb_cov_sum_collector.sv
// Scoreboard bench for cov_sum_collector: the driver schedules expected values
// by cycle, a negedge monitor pops and compares them. Honours COV_DROP_CNT_EN.
module tb_cov_sum_collector;

   localparam int unsigned MB = 10;
   localparam int unsigned SW = 30;

   localparam int K_SUM   = 0;
   localparam int K_READY = 1;
   localparam int K_CLR   = 2;
   localparam int K_DROP  = 3;

   typedef struct {
      int cyc;
      int kind;
      int val;
   } exp_t;

   logic          clock;
   logic          reset;
   logic          meta_reset;
   logic          cov_valid;
   logic [MB-1:0] cov_idx;
   logic          cov_ready;
   logic [SW-1:0] cov_sum;
   logic          clearing;
`ifdef COV_DROP_CNT_EN
   logic [15:0]   cov_drop;
`endif

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   cov_sum_collector #(
      .MAP_BITS (MB),
      .SUM_W    (SW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .meta_reset (meta_reset),
      .cov_valid  (cov_valid),
      .cov_idx    (cov_idx),
      .cov_ready  (cov_ready),
      .cov_sum    (cov_sum),
      .clearing   (clearing)
`ifdef COV_DROP_CNT_EN
      ,
      .cov_drop   (cov_drop)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic push(input int c, input int kind, input int val);
      exp_t e;
      int   p;
      e.cyc  = c;
      e.kind = kind;
      e.val  = val;
      p = sb.size();
      while (p > 0 && sb[p-1].cyc > c) p--;
      sb.insert(p, e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) tick();
   endtask

   // Bitmap sweep starting in CLEAR after edge s: 32 cycles clearing, then RUN.
   task automatic expect_sweep(input int s);
      for (int c = s; c < s + 32; c++) begin
         push(c, K_CLR, 1);
         push(c, K_READY, 0);
      end
      push(s + 32, K_CLR, 0);
      push(s + 32, K_READY, 1);
      push(s + 32, K_SUM, 0);
   endtask

   // Offer one hit this cycle; cov_sum reflects it two edges later.
   task automatic hit(input int idx, input int exp_sum);
      cov_valid = 1'b1;
      cov_idx   = MB'(idx);
      if (exp_sum >= 0) push(cyc + 2, K_SUM, exp_sum);
      tick();
   endtask

   // Monitor: compare every expectation scheduled for the current cycle.
   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t  e;
         int    act;
         string nm;
         e   = sb.pop_front();
         act = -1;
         nm  = "?";
         case (e.kind)
            K_SUM:   begin act = int'(cov_sum);   nm = "cov_sum";   end
            K_READY: begin act = int'(cov_ready); nm = "cov_ready"; end
            K_CLR:   begin act = int'(clearing);  nm = "clearing";  end
`ifdef COV_DROP_CNT_EN
            K_DROP:  begin act = int'(cov_drop);  nm = "cov_drop";  end
`endif
            default: ;
         endcase
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL stale_%s: scheduled cycle %0d, seen at cycle %0d", nm, e.cyc, cyc);
         end else if (act != e.val) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, e.val);
         end
      end
   end

   initial begin
      int t;
      reset      = 1'b0;
      meta_reset = 1'b0;
      cov_valid  = 1'b0;
      cov_idx    = '0;

      // Power-on reset for one edge, then the initial sweep.
      tick();
      reset = 1'b1;
      expect_sweep(cyc);
`ifdef COV_DROP_CNT_EN
      push(cyc + 32, K_DROP, 0);
`endif
      wait_cyc(33);

      // Duplicate index counts once.
      hit(5, 1);
      hit(5, 1);
      hit(900, 2);
      cov_valid = 1'b0;
      push(cyc + 2, K_SUM, 2);
      tick();
      tick();

      // meta_reset while a hit sits in stage 1.
      hit(7, -1);
      t = cyc;
      cov_valid  = 1'b0;
      meta_reset = 1'b1;
      push(t, K_READY, 0);
      push(t, K_SUM, 2);
      tick();
      meta_reset = 1'b0;
      expect_sweep(t + 1);
      push(t + 1, K_SUM, 0);
      wait_cyc(t + 33);
      hit(5, 1);
      cov_valid = 1'b0;
      tick();
      tick();

      // meta_reset coinciding with an offered hit; valid held through sweep.
      t = cyc;
      cov_valid  = 1'b1;
      cov_idx    = MB'(3);
      meta_reset = 1'b1;
      push(t, K_READY, 0);
`ifdef COV_DROP_CNT_EN
      push(t, K_DROP, 0);
      push(t + 33, K_DROP, 33);
      push(t + 34, K_DROP, 33);
`endif
      tick();
      meta_reset = 1'b0;
      expect_sweep(t + 1);
      push(t + 1, K_SUM, 0);
      wait_cyc(t + 33);
      cov_valid = 1'b0;
      push(t + 35, K_SUM, 0);
      tick();
      tick();
      tick();

      // Every index once, then every index again.
      for (int i = 0; i < 1024; i++) hit(i, i + 1);
      for (int i = 0; i < 1024; i++) hit(i, 1024);
      cov_valid = 1'b0;
      push(cyc + 2, K_SUM, 1024);
      push(cyc + 5, K_SUM, 1024);
      for (int i = 0; i < 6; i++) tick();

      // Reset with a hit in flight abandons it and forces a full sweep.
      t = cyc;
      cov_valid = 1'b1;
      cov_idx   = MB'(9);
      reset     = 1'b0;
      tick();
      reset     = 1'b1;
      cov_valid = 1'b0;
      expect_sweep(t + 1);
      push(t + 1, K_SUM, 0);
`ifdef COV_DROP_CNT_EN
      push(t + 33, K_DROP, 0);
`endif
      wait_cyc(t + 33);
      hit(9, 1);
      cov_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
